// File: rtl/oven_pkg.sv
// rtl/oven_pkg.sv - shared types and constants for the oven cook timer
package oven_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } timer_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t MAX_MIN_TENS = 4'd9;
  localparam bcd_t MAX_SEC_TENS = 4'd5;
  localparam bcd_t MAX_DIGIT    = 4'd9;

endpackage

// File: rtl/oven_cook_timer_tick_gen.sv
// rtl/oven_cook_timer_tick_gen.sv - one-second prescaler producing a single-cycle tick enable
module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/oven_cook_timer.sv
// rtl/oven_cook_timer.sv - BCD MM:SS countdown cook timer with pause, door interlock and expiry beep
module oven_cook_timer #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BEEP_SECS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       add_min,
  input  logic       add_10s,
  input  logic       door_open,
  output logic [3:0] secCountVal1,
  output logic [3:0] secCountVal2,
  output logic [3:0] minCountVal1,
  output logic [3:0] minCountVal2,
  output logic       running,
  output logic       done,
  output logic       beep
);

  import oven_pkg::*;

  localparam int BW = (BEEP_SECS > 1) ? $clog2(BEEP_SECS + 1) : 1;
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_SECS - 1);

  timer_state_t state_q, state_d;
  bcd_t so_q, st_q, mo_q, mt_q;
  bcd_t so_d, st_d, mo_d, mt_d;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic running_d, done_d, beep_d;
  logic running_q, done_q, beep_q;
  logic tick, presc_clr, presc_en;
  logic is_zero, is_one, min99, start_ok;

  assign is_zero  = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);
  assign is_one   = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd1);
  assign min99    = (mt_q == MAX_MIN_TENS) && (mo_q == MAX_DIGIT);
  assign start_ok = !is_zero && !door_open;
  assign presc_en = (state_q == RUN) || (state_q == DONE);

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (presc_clr),
    .en   (presc_en),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // stop masks start, so a coincident stop+start outside RUN does nothing
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, PAUSED: if (!stop && start && start_ok) state_d = RUN;
        RUN: begin
          if (stop || door_open)  state_d = PAUSED;
          else if (tick && is_one) state_d = DONE;
        end
        DONE: if (tick && (beep_cnt_q == BEEP_LAST)) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
    beep_d    = (state_d == DONE);
  end

  always_comb begin
    so_d       = so_q;
    st_d       = st_q;
    mo_d       = mo_q;
    mt_d       = mt_q;
    beep_cnt_d = beep_cnt_q;
    presc_clr  = 1'b0;
    if (clear) begin
      so_d       = 4'd0;
      st_d       = 4'd0;
      mo_d       = 4'd0;
      mt_d       = 4'd0;
      beep_cnt_d = '0;
      presc_clr  = 1'b1;
    end else begin
      case (state_q)
        IDLE, PAUSED: begin
          if (stop) begin
            so_d = so_q;
          end else if (start) begin
            presc_clr = start_ok;
          end else if (add_min) begin
            if (min99) begin
              st_d = MAX_SEC_TENS;
              so_d = MAX_DIGIT;
            end else if (mo_q == MAX_DIGIT) begin
              mo_d = 4'd0;
              mt_d = mt_q + 4'd1;
            end else begin
              mo_d = mo_q + 4'd1;
            end
          end else if (add_10s) begin
            if (st_q != MAX_SEC_TENS) begin
              st_d = st_q + 4'd1;
            end else if (min99) begin
              so_d = MAX_DIGIT;
            end else begin
              st_d = 4'd0;
              if (mo_q == MAX_DIGIT) begin
                mo_d = 4'd0;
                mt_d = mt_q + 4'd1;
              end else begin
                mo_d = mo_q + 4'd1;
              end
            end
          end
        end
        RUN: begin
          if (!stop && !door_open && tick) begin
            beep_cnt_d = '0;
            so_d = (so_q == 4'd0) ? MAX_DIGIT : so_q - 4'd1;
            if (so_q == 4'd0) begin
              st_d = (st_q == 4'd0) ? MAX_SEC_TENS : st_q - 4'd1;
              if (st_q == 4'd0) begin
                mo_d = (mo_q == 4'd0) ? MAX_DIGIT : mo_q - 4'd1;
                if (mo_q == 4'd0) mt_d = mt_q - 4'd1;
              end
            end
          end
        end
        DONE: if (tick) beep_cnt_d = beep_cnt_q + 1'b1;
        default: beep_cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      so_q       <= 4'd0;
      st_q       <= 4'd0;
      mo_q       <= 4'd0;
      mt_q       <= 4'd0;
      beep_cnt_q <= '0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      beep_q     <= 1'b0;
    end else begin
      so_q       <= so_d;
      st_q       <= st_d;
      mo_q       <= mo_d;
      mt_q       <= mt_d;
      beep_cnt_q <= beep_cnt_d;
      running_q  <= running_d;
      done_q     <= done_d;
      beep_q     <= beep_d;
    end
  end

  assign secCountVal1 = so_q;
  assign secCountVal2 = st_q;
  assign minCountVal1 = mo_q;
  assign minCountVal2 = mt_q;
  assign running      = running_q;
  assign done         = done_q;
  assign beep         = beep_q;

endmodule

// File: tb/tb_oven_cook_timer.sv
// tb/tb_oven_cook_timer.sv - directed scoreboard bench for oven_cook_timer
module tb_oven_cook_timer;

  localparam int CLK_HZ    = 4;
  localparam int BEEP_SECS = 2;

  localparam logic [4:0] P_START = 5'b00001;
  localparam logic [4:0] P_STOP  = 5'b00010;
  localparam logic [4:0] P_CLEAR = 5'b00100;
  localparam logic [4:0] P_MIN   = 5'b01000;
  localparam logic [4:0] P_10S   = 5'b10000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, clear = 1'b0, add_min = 1'b0, add_10s = 1'b0;
  logic door_open = 1'b0;
  logic [3:0] sec1, sec2, min1, min2;
  logic running, done, beep;

  oven_cook_timer #(.CLK_HZ(CLK_HZ), .BEEP_SECS(BEEP_SECS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .add_min     (add_min),
    .add_10s     (add_10s),
    .door_open   (door_open),
    .secCountVal1(sec1),
    .secCountVal2(sec2),
    .minCountVal1(min1),
    .minCountVal2(min2),
    .running     (running),
    .done        (done),
    .beep        (beep)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [18:0] val;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  function automatic logic [18:0] pack(input int mm, input int ss, input logic r, input logic d, input logic b);
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), r, d, b};
  endfunction

  task automatic push(input string tag, input int mm, input int ss, input logic r, input logic d, input logic b);
    exp_t e;
    e.tag = tag;
    e.val = pack(mm, ss, r, d, b);
    sb.push_back(e);
  endtask

  task automatic chk();
    exp_t e;
    logic [18:0] o;
    o = {min2, min1, sec2, sec1, running, done, beep};
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h", o);
    end else begin
      e = sb.pop_front();
      assert (o === e.val) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic press(input logic [4:0] m);
    @(negedge clk);
    {add_10s, add_min, clear, stop, start} = m;
    @(negedge clk);
    {add_10s, add_min, clear, stop, start} = 5'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    push("reset_state", 0, 0, 0, 0, 0);
    #13;
    chk();
    @(negedge clk);
    rst_n = 1'b1;

    push("load_01_20", 1, 20, 0, 0, 0);
    press(P_10S); press(P_10S); press(P_MIN);
    chk();
    push("carry_02_00", 2, 0, 0, 0, 0);
    repeat (4) press(P_10S);
    chk();
    press(P_CLEAR);

    press(P_10S);
    push("run_00_10", 0, 10, 1, 0, 0);
    press(P_START);
    chk();
    push("run_00_03", 0, 3, 1, 0, 0);
    cycles(28);
    chk();
    push("pause_00_03", 0, 3, 0, 0, 0);
    press(P_STOP);
    chk();
    push("resume_00_03", 0, 3, 1, 0, 0);
    press(P_START);
    chk();
    push("tick_00_02", 0, 2, 1, 0, 0);
    cycles(4);
    chk();
    push("pre_expiry_00_01", 0, 1, 1, 0, 0);
    cycles(7);
    chk();
    push("expiry", 0, 0, 0, 1, 1);
    cycles(1);
    chk();
    push("beep_held", 0, 0, 0, 1, 1);
    cycles(7);
    chk();
    push("beep_end_idle", 0, 0, 0, 0, 0);
    cycles(1);
    chk();

    press(P_MIN);
    push("run_01_00", 1, 0, 1, 0, 0);
    press(P_START);
    chk();
    push("run_00_59", 0, 59, 1, 0, 0);
    cycles(4);
    chk();
    door_open = 1'b1;
    push("door_pause", 0, 59, 0, 0, 0);
    cycles(1);
    chk();
    push("paused_hold", 0, 59, 0, 0, 0);
    cycles(6);
    chk();
    push("start_door_open_ignored", 0, 59, 0, 0, 0);
    press(P_START);
    chk();
    door_open = 1'b0;
    push("resume_door_closed", 0, 59, 1, 0, 0);
    press(P_START);
    chk();
    push("resume_full_second", 0, 59, 1, 0, 0);
    cycles(3);
    chk();
    push("resume_tick_00_58", 0, 58, 1, 0, 0);
    cycles(1);
    chk();
    push("clear_in_run", 0, 0, 0, 0, 0);
    press(P_CLEAR);
    chk();

    push("min_99_00", 99, 0, 0, 0, 0);
    repeat (99) press(P_MIN);
    chk();
    push("sec_99_50", 99, 50, 0, 0, 0);
    repeat (5) press(P_10S);
    chk();
    push("clamp_10s", 99, 59, 0, 0, 0);
    press(P_10S);
    chk();
    push("clamp_min", 99, 59, 0, 0, 0);
    press(P_MIN);
    chk();
    push("clear_99_59", 0, 0, 0, 0, 0);
    press(P_CLEAR);
    chk();

    repeat (3) press(P_10S);
    press(P_START);
    push("paused_00_30", 0, 30, 0, 0, 0);
    press(P_STOP);
    chk();
    push("start_clear_paused", 0, 0, 0, 0, 0);
    press(P_START | P_CLEAR);
    chk();
    push("start_zero_ignored", 0, 0, 0, 0, 0);
    press(P_START);
    chk();
    push("start_masks_add_min", 0, 0, 0, 0, 0);
    press(P_START | P_MIN);
    chk();
    repeat (2) press(P_10S);
    press(P_START);
    push("stop_beats_start", 0, 20, 0, 0, 0);
    press(P_STOP | P_START);
    chk();
    press(P_CLEAR);

    repeat (4) press(P_10S);
    press(P_START);
    cycles(2);
    #2;
    rst_n = 1'b0;
    #1;
    push("async_reset", 0, 0, 0, 0, 0);
    chk();
    @(negedge clk);
    rst_n = 1'b1;
    push("after_reset_idle", 0, 0, 0, 0, 0);
    cycles(5);
    chk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oven_cook_timer.md
# oven_cook_timer

Down-counting cook timer for the oven front panel. It is the countdown counterpart to the free-running time-of-day clock. The user loads a time in BCD MM:SS (00:00–99:59) with add-keys, then starts, pauses or clears it. The value decrements once per second, and on reaching 00:00 the block raises `done` and drives a timed beep. It drives the same four 7-segment digit positions through the panel display mux.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: input clock frequency; one second = `CLK_HZ` cycles.
- `BEEP_SECS`, 3: whole seconds `beep` stays high after expiry.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle pulse: run / resume.
- `stop`  in  1  one-cycle pulse: pause.
- `clear`  in  1  one-cycle pulse: abort and zero.
- `add_min`  in  1  one-cycle pulse: +1 minute.
- `add_10s`  in  1  one-cycle pulse: +10 seconds.
- `door_open`  in  1  level, door switch.
- `secCountVal1`, `secCountVal2`, `minCountVal1`, `minCountVal2`  out  4 each  BCD digits: seconds ones/tens, minutes ones/tens.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `beep`  out  1  buzzer enable.

## Operation
- States:
  - IDLE: reset state.
  - RUN
  - PAUSED
  - DONE
- Reset: all digits 0, state IDLE, prescaler 0, `running`=`done`=`beep`=0.
- Priority when pulses coincide in one cycle: `clear` > `stop` > `start` > `add_min` > `add_10s`. Only the highest-priority pulse acts.
- `clear` in any state sets the digits to 00:00, the state to IDLE, and the prescaler and beep counter to 0.
- Add-keys act only in IDLE and PAUSED; they are ignored in RUN and DONE.
  - `add_min`: minutes +1 in BCD. At 99 minutes the value clamps to 99:59.
  - `add_10s`: seconds tens +1. Going from 5 to 0 carries into minutes. A result above 99:59 clamps to 99:59.
- `start` moves IDLE or PAUSED to RUN only when the value is not 00:00 and `door_open`=0. Otherwise it is ignored.
- `stop` moves RUN to PAUSED. In any other state it does nothing.
- `door_open`=1 while in RUN moves to PAUSED on the next edge.
- RUN countdown:
  - The prescaler counts 0..`CLK_HZ`-1. A tick occurs when it wraps.
  - On each tick, decrement BCD MM:SS. Seconds ones 0 borrows to 9. Seconds tens 0 borrows to 5. Minutes borrow similarly.
  - A tick on 00:01 writes 00:00 and moves the state to DONE.
- DONE:
  - `beep`=1 for exactly `BEEP_SECS` ticks, then `beep`=0 and the state moves to IDLE with digits 00:00.
  - `start` in DONE is ignored.
- Digits must never hold non-BCD values. Seconds tens are never above 5.

## Timing
- All outputs are registered and change only on `clk` rising edges. The exception is the asynchronous reset.
- Prescaler behaviour:
  - Cleared on every entry to RUN, so the first decrement occurs `CLK_HZ` cycles after the cycle in which `start` is sampled.
  - Holds its value in PAUSED. Resume continues from a cleared prescaler, so a full second elapses before the next decrement.
- Command latency: pulses take effect on the edge that samples them, so outputs update one cycle after the pulse.
- The tick on 00:01 drives digits 00:00, `running`=0, `done`=1 and `beep`=1 on the same edge.
- A tick in the same cycle as `stop`, `clear` or `door_open` causes no decrement.
- Beep duration: `BEEP_SECS`×`CLK_HZ` cycles. The prescaler runs in DONE, cleared on entry.
- Asserting `rst_n` mid-countdown immediately forces all reset values.

## Structure
- Shared package `oven_pkg`:
  - state enum `timer_state_t` (IDLE, RUN, PAUSED, DONE)
  - BCD digit type
  - constants `MAX_MIN_TENS`=9, `MAX_SEC_TENS`=5
- Sub-module `tick_gen` (parameter `CLK_HZ`; inputs `clk`, `rst_n`, `clr`, `en`; output `tick`): a one-cycle enable, not a derived clock.
- The BCD decrement and add logic stay inline.

## Test plan
Simulate with `CLK_HZ`=4 and `BEEP_SECS`=2.
- Reset, then `add_10s` ×2, then `add_min` ×1 -> digits 01:20, IDLE.
- From 00:03, `start` -> `running`=1. Digits read 00:02 after 4 cycles and 00:00 after 12 cycles, with `done`=1 and `beep`=1. `beep` drops after 8 more cycles, then IDLE.
- From 01:00, `start`, then after 4 cycles the value is 00:59. `door_open`=1 -> PAUSED, value held at 00:59. `start` with the door open is ignored. Door closed plus `start` resumes, and 00:58 appears 4 cycles later.
- From 99:50, `add_10s` -> 99:59. `add_min` -> 99:59, unchanged.
- Simultaneous `start`+`clear` in PAUSED at 00:30 -> 00:00, IDLE. `start` at 00:00 is ignored.
- Assert `rst_n`=0 mid-RUN at 00:40 -> digits 00:00 and all flags 0 immediately, without waiting for a clock edge.
